// File: rtl/tt_sweep_pkg.sv
// Shared state encoding and sizing helpers for the truth-table sweep checker.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Width of a counter that must represent 0..hold_cycles.
    function automatic int hold_cnt_w(input int hold_cycles);
        return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Purpose: loadable down-counter that flags expiry after HOLD_CYCLES counted cycles.
// Latency: expire is combinational from the count; load/clr take effect on the next edge.
// Backpressure: none; counts whenever enabled and saturates at zero.
module tt_hold_timer #(
    parameter int HOLD_CYCLES = 1,
    parameter int W           = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    // Loading HOLD_CYCLES-1 gives exactly HOLD_CYCLES enabled cycles until expiry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(HOLD_CYCLES - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Purpose: exhaustive stimulus sweep of a combinational block, compared against a latched truth table.
// Latency: done rises exactly 2**N_IN*(HOLD_CYCLES+1) edges after the accepted start.
// Backpressure: start is ignored while busy; optional TT_SWEEP_FIRST_FAIL_EN adds first_fail reporting.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 dut_y,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count
`ifdef TT_SWEEP_FIRST_FAIL_EN
    ,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_vld
`endif
);

    localparam int NV = 2**N_IN;
    localparam int HW = hold_cnt_w(HOLD_CYCLES);

    state_t          state_q, state_d;
    logic [NV-1:0]   tt_q;
    logic            start_acc;
    logic            tmr_load, tmr_clr, expire;
    logic            last_vec, mismatch;
    logic [N_IN:0]   err_next;

    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_vec  = &stim;
    assign mismatch  = (state_q == S_CHECK) && (dut_y != tt_q[stim]);
    assign err_next  = err_count + {{N_IN{1'b0}}, mismatch};

    tt_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .W           (HW)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .clr    (tmr_clr),
        .en     (state_q == S_DRIVE),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    tmr_load = 1'b1;
                end
            end
            S_DRIVE: begin
                if (expire) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (last_vec) begin
                    state_d = S_DONE;
                    tmr_clr = 1'b1;
                end else begin
                    state_d  = S_DRIVE;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result registers; pass uses err_next so a mismatch on the final vector counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            tt_q      <= '0;
`ifdef TT_SWEEP_FIRST_FAIL_EN
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
`endif
        end else if (start_acc) begin
            stim      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            tt_q      <= exp_tt;
`ifdef TT_SWEEP_FIRST_FAIL_EN
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
`endif
        end else if (state_q == S_CHECK) begin
            err_count <= err_next;
`ifdef TT_SWEEP_FIRST_FAIL_EN
            if (mismatch && !first_fail_vld) begin
                first_fail     <= stim;
                first_fail_vld <= 1'b1;
            end
`endif
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_next == '0);
            end else begin
                stim <= stim + N_IN'(1);
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: two instances (N_IN=2/HOLD=1 and N_IN=3/HOLD=3) with a done-driven scoreboard.
module tb_tt_sweep_checker;

    typedef struct {
        longint done_cyc;
        int     err;
        bit     pass;
        int     ff;
        bit     ff_vld;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    longint     cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    // Instance A: N_IN=2, HOLD_CYCLES=1
    logic       start2 = 1'b0;
    logic [3:0] exp2   = 4'b0110;
    logic       dut_y2;
    logic [1:0] stim2;
    logic       busy2, done2, pass2;
    logic [2:0] err2;
    int         mode2 = 0;
    exp_t       q2[$];
    exp_t       e2;
    logic       done2_prev = 1'b0;

    // Instance B: N_IN=3, HOLD_CYCLES=3
    logic       start3 = 1'b0;
    logic [7:0] exp3   = 8'h80;
    logic       dut_y3;
    logic [2:0] stim3;
    logic       busy3, done3, pass3;
    logic [3:0] err3;
    exp_t       q3[$];
    exp_t       e3;
    logic       done3_prev = 1'b0;

`ifdef TT_SWEEP_FIRST_FAIL_EN
    logic [1:0] ff2;
    logic       ffv2;
    logic [2:0] ff3;
    logic       ffv3;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode2: 0 = XOR gate, 1 = output stuck at 0
    always_comb dut_y2 = (mode2 == 0) ? (stim2[1] ^ stim2[0]) : 1'b0;
    always_comb dut_y3 = &stim3;

    tt_sweep_checker #(.N_IN(2), .HOLD_CYCLES(1)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .exp_tt    (exp2),
        .dut_y     (dut_y2),
        .stim      (stim2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err2)
`ifdef TT_SWEEP_FIRST_FAIL_EN
        ,
        .first_fail     (ff2),
        .first_fail_vld (ffv2)
`endif
    );

    tt_sweep_checker #(.N_IN(3), .HOLD_CYCLES(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .start     (start3),
        .exp_tt    (exp3),
        .dut_y     (dut_y3),
        .stim      (stim3),
        .busy      (busy3),
        .done      (done3),
        .pass      (pass3),
        .err_count (err3)
`ifdef TT_SWEEP_FIRST_FAIL_EN
        ,
        .first_fail     (ff3),
        .first_fail_vld (ffv3)
`endif
    );

    task automatic chk(input string nm, input longint got, input longint want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Monitors: pop one expectation per rising done.
    always @(negedge clk) begin
        if (done2 && !done2_prev) begin
            if (q2.size() == 0) begin
                chk("sb2_unexpected_done", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("sb2_done_cycle", cyc, e2.done_cyc);
                chk("sb2_err_count", err2, e2.err);
                chk("sb2_pass", pass2, e2.pass);
                chk("sb2_busy", busy2, 0);
                chk("sb2_stim_held", stim2, 3);
`ifdef TT_SWEEP_FIRST_FAIL_EN
                chk("sb2_first_fail_vld", ffv2, e2.ff_vld);
                chk("sb2_first_fail", ff2, e2.ff);
`endif
            end
        end
        done2_prev = done2;
    end

    always @(negedge clk) begin
        if (done3 && !done3_prev) begin
            if (q3.size() == 0) begin
                chk("sb3_unexpected_done", 1, 0);
            end else begin
                e3 = q3.pop_front();
                chk("sb3_done_cycle", cyc, e3.done_cyc);
                chk("sb3_err_count", err3, e3.err);
                chk("sb3_pass", pass3, e3.pass);
`ifdef TT_SWEEP_FIRST_FAIL_EN
                chk("sb3_first_fail_vld", ffv3, e3.ff_vld);
                chk("sb3_first_fail", ff3, e3.ff);
`endif
            end
        end
        done3_prev = done3;
    end

    // Pulse start on instance A and push its expected result; returns at the negedge after the accepting edge.
    task automatic go2(input logic [3:0] tt, input int err, input bit ps, input int ff, input bit ffv);
        exp_t e;
        @(negedge clk);
        exp2   = tt;
        start2 = 1'b1;
        e.done_cyc = cyc + 1 + 4 * 2;
        e.err = err; e.pass = ps; e.ff = ff; e.ff_vld = ffv;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done2(input string nm);
        int n = 0;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done2) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_stim", stim2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_pass", pass2, 0);
        chk("rst_err", err2, 0);
        chk("rst_busy3", busy3, 0);

        // XOR sweep: stim steps 0,1,2,3 every two cycles
        mode2 = 0;
        go2(4'b0110, 0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("step_stim_%0d", k), stim2, k / 2);
            chk($sformatf("step_busy_%0d", k), busy2, 1);
            @(negedge clk);
        end
        wait_done2("xor");

        // Stuck-at-0 output: vectors 1 and 2 mismatch, first at stim=1
        mode2 = 1;
        go2(4'b0110, 2, 1'b0, 1, 1'b1);
        wait_done2("stuck0");

        // Restart from DONE with err_count=2: results clear on the accepting edge
        mode2 = 0;
        go2(4'b0110, 0, 1'b1, 0, 1'b0);
        chk("restart_done_drop", done2, 0);
        chk("restart_err_clear", err2, 0);
        chk("restart_pass_clear", pass2, 0);
        chk("restart_busy", busy2, 1);
        wait_done2("restart");

        // A second start during the sweep is ignored
        mode2 = 1;
        go2(4'b0110, 2, 1'b0, 1, 1'b0 | 1'b1);
        @(negedge clk);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("ignored_start_stim", stim2, 1);
        chk("ignored_start_busy", busy2, 1);
        wait_done2("ignored_start");

        // Reset in mid-sweep while stim=2 discards the sweep
        go2(4'b0110, 0, 1'b0, 0, 1'b0);
        n = 0;
        while (stim2 != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reach_stim2", stim2, 2);
        chk("midrst_err_before", err2, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q2.delete();
        chk("midrst_stim", stim2, 0);
        chk("midrst_busy", busy2, 0);
        chk("midrst_done", done2, 0);
        chk("midrst_err", err2, 0);
`ifdef TT_SWEEP_FIRST_FAIL_EN
        chk("midrst_ffv", ffv2, 0);
`endif

        // rst and start on the same edge: start dropped
        rst    = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy2, 0);
        chk("rst_start_done", done2, 0);

        // Normal sweep after reset
        mode2 = 0;
        go2(4'b0110, 0, 1'b1, 0, 1'b0);
        wait_done2("post_rst");

        // Instance B: AND3, table changed mid-sweep must not matter
        @(negedge clk);
        exp3   = 8'h80;
        start3 = 1'b1;
        e.done_cyc = cyc + 1 + 8 * 4;
        e.err = 0; e.pass = 1'b1; e.ff = 0; e.ff_vld = 1'b0;
        q3.push_back(e);
        @(negedge clk);
        start3 = 1'b0;
        repeat (5) @(negedge clk);
        exp3 = 8'h00;
        n = 0;
        while (!done3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done3) chk("and3_timeout", 0, 1);
        @(negedge clk);

        chk("sb2_queue_drained", q2.size(), 0);
        chk("sb3_queue_drained", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
